// File: rtl/mat_gram_cplx_stream.sv
`default_nettype none
// ============================================================================
// Module   : mat_gram_cplx_stream
// Purpose  : Complex Gram / cross-correlation engine. Loads two complex
//            matrices Z and J (ROWS x LEN) over a valid/ready stream. For
//            every (r,c) it then computes Z(r)*J(c)^H and J(r)*J(c)^H, or the
//            conjugate-first variant, on one time-shared MAC lane. The
//            ROWS*ROWS result pairs are streamed out with backpressure.
// Ports    : clk, rst                      clock / sync active-high reset
//            mode_i                        0: z*conj(j), 1: conj(z)*j
//            in_valid_i / in_ready_o       load beat handshake
//            in_{z,j}_{re,im}_i            one Z and one J element per beat
//            out_valid_o / out_ready_i     result handshake
//            out_row_o / out_col_o         result indices
//            out_{zj,jj}_{re,im}_o         cross and auto results
//            out_last_o                    marks the (ROWS-1,ROWS-1) result
//            busy_o                        computing or presenting results
// Revision : 1.0 - initial release
// ============================================================================
module mat_gram_cplx_stream #(
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int LEN   = 64,
  parameter int ACC_W = 2*DW+1+$clog2(LEN),
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [DW-1:0]    in_z_re_i,
  input  logic signed [DW-1:0]    in_z_im_i,
  input  logic signed [DW-1:0]    in_j_re_i,
  input  logic signed [DW-1:0]    in_j_im_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [RW-1:0]           out_row_o,
  output logic [RW-1:0]           out_col_o,
  output logic signed [ACC_W-1:0] out_zj_re_o,
  output logic signed [ACC_W-1:0] out_zj_im_o,
  output logic signed [ACC_W-1:0] out_jj_re_o,
  output logic signed [ACC_W-1:0] out_jj_im_o,
  output logic                    out_last_o,
  output logic                    busy_o
);

  localparam int NB = ROWS * LEN;
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(LEN + 3);
  localparam int PW = 2*DW + 1;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ld_q, ld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   col_q, col_d;
  logic            mode_q;

  logic            w_in_fire;
  logic            w_last_beat;
  logic            w_last_pair;
  logic            w_issue;
  logic            w_done;
  logic [AW-1:0]   w_addr_a;
  logic [AW-1:0]   w_addr_b;

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_OUTPUT);
  assign busy_o      = (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;

  assign w_in_fire   = in_valid_i && in_ready_o;
  assign w_last_beat = (ld_q == AW'(NB - 1));
  assign w_last_pair = (row_q == RW'(ROWS - 1)) && (col_q == RW'(ROWS - 1));
  assign out_last_o  = out_valid_o && w_last_pair;

  // Reads are issued on the first LEN compute cycles; the remaining three
  // cycles drain the read/product/accumulate pipeline.
  assign w_issue  = (state_q == S_COMPUTE) && (cnt_q < CW'(LEN));
  assign w_done   = (state_q == S_COMPUTE) && (cnt_q == CW'(LEN + 2));
  assign w_addr_a = AW'(row_q) * AW'(LEN) + AW'(cnt_q);
  assign w_addr_b = AW'(col_q) * AW'(LEN) + AW'(cnt_q);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_LOAD: begin
        if (w_in_fire) begin
          if (w_last_beat) begin
            ld_d    = '0;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            ld_d = ld_q + AW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (w_done) begin
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready_i) begin
          cnt_d = '0;
          if (w_last_pair) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_COMPUTE;
            if (col_q == RW'(ROWS - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      ld_q    <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      // Mode is latched once per matrix set, on its first beat.
      if (w_in_fire && (ld_q == '0)) begin
        mode_q <= mode_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Matrix storage (contents are don't-care after reset)
  // --------------------------------------------------------------------------
  logic signed [DW-1:0] mem_zr [NB];
  logic signed [DW-1:0] mem_zi [NB];
  logic signed [DW-1:0] mem_jr [NB];
  logic signed [DW-1:0] mem_ji [NB];

  logic signed [DW-1:0] rd_zr_q, rd_zi_q;
  logic signed [DW-1:0] rd_ja_re_q, rd_ja_im_q;   // J row r
  logic signed [DW-1:0] rd_jb_re_q, rd_jb_im_q;   // J row c (conjugated side)

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      mem_zr[ld_q] <= in_z_re_i;
      mem_zi[ld_q] <= in_z_im_i;
      mem_jr[ld_q] <= in_j_re_i;
      mem_ji[ld_q] <= in_j_im_i;
    end
    if (w_issue) begin
      rd_zr_q    <= mem_zr[w_addr_a];
      rd_zi_q    <= mem_zi[w_addr_a];
      rd_ja_re_q <= mem_jr[w_addr_a];
      rd_ja_im_q <= mem_ji[w_addr_a];
      rd_jb_re_q <= mem_jr[w_addr_b];
      rd_jb_im_q <= mem_ji[w_addr_b];
    end
  end

  // --------------------------------------------------------------------------
  // MAC lane: read register -> product register -> accumulator
  // --------------------------------------------------------------------------
  logic signed [2*DW-1:0] w_p_zr_br, w_p_zi_bi, w_p_zi_br, w_p_zr_bi;
  logic signed [2*DW-1:0] w_p_ar_br, w_p_ai_bi, w_p_ai_br, w_p_ar_bi;
  logic signed [PW-1:0]   w_zj_re, w_zj_im, w_jj_re, w_jj_im;

  assign w_p_zr_br = rd_zr_q    * rd_jb_re_q;
  assign w_p_zi_bi = rd_zi_q    * rd_jb_im_q;
  assign w_p_zi_br = rd_zi_q    * rd_jb_re_q;
  assign w_p_zr_bi = rd_zr_q    * rd_jb_im_q;
  assign w_p_ar_br = rd_ja_re_q * rd_jb_re_q;
  assign w_p_ai_bi = rd_ja_im_q * rd_jb_im_q;
  assign w_p_ai_br = rd_ja_im_q * rd_jb_re_q;
  assign w_p_ar_bi = rd_ja_re_q * rd_jb_im_q;

  // Real parts are mode independent; conjugating the other operand only
  // flips the sign of the imaginary part.
  assign w_zj_re = PW'(w_p_zr_br) + PW'(w_p_zi_bi);
  assign w_jj_re = PW'(w_p_ar_br) + PW'(w_p_ai_bi);
  assign w_zj_im = mode_q ? (PW'(w_p_zr_bi) - PW'(w_p_zi_br))
                          : (PW'(w_p_zi_br) - PW'(w_p_zr_bi));
  assign w_jj_im = mode_q ? (PW'(w_p_ar_bi) - PW'(w_p_ai_br))
                          : (PW'(w_p_ai_br) - PW'(w_p_ar_bi));

  logic signed [PW-1:0]    prd_zj_re_q, prd_zj_im_q, prd_jj_re_q, prd_jj_im_q;
  logic signed [ACC_W-1:0] acc_zj_re_q, acc_zj_im_q, acc_jj_re_q, acc_jj_im_q;
  logic                    rd_vld_q, prd_vld_q;

  always_ff @(posedge clk) begin
    if (rd_vld_q) begin
      prd_zj_re_q <= w_zj_re;
      prd_zj_im_q <= w_zj_im;
      prd_jj_re_q <= w_jj_re;
      prd_jj_im_q <= w_jj_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q    <= 1'b0;
      prd_vld_q   <= 1'b0;
      acc_zj_re_q <= '0;
      acc_zj_im_q <= '0;
      acc_jj_re_q <= '0;
      acc_jj_im_q <= '0;
      out_zj_re_o <= '0;
      out_zj_im_o <= '0;
      out_jj_re_o <= '0;
      out_jj_im_o <= '0;
    end else begin
      rd_vld_q  <= w_issue;
      prd_vld_q <= rd_vld_q;
      // The pipeline is empty on the first compute cycle of a pair, so the
      // clear never collides with a pending product.
      if ((state_q == S_COMPUTE) && (cnt_q == '0)) begin
        acc_zj_re_q <= '0;
        acc_zj_im_q <= '0;
        acc_jj_re_q <= '0;
        acc_jj_im_q <= '0;
      end else if (prd_vld_q) begin
        acc_zj_re_q <= acc_zj_re_q + ACC_W'(prd_zj_re_q);
        acc_zj_im_q <= acc_zj_im_q + ACC_W'(prd_zj_im_q);
        acc_jj_re_q <= acc_jj_re_q + ACC_W'(prd_jj_re_q);
        acc_jj_im_q <= acc_jj_im_q + ACC_W'(prd_jj_im_q);
      end
      // Result registers hold steady for the whole OUTPUT state.
      if (w_done) begin
        out_zj_re_o <= acc_zj_re_q;
        out_zj_im_o <= acc_zj_im_q;
        out_jj_re_o <= acc_jj_re_q;
        out_jj_im_o <= acc_jj_im_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_gram_cplx_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_gram_cplx_stream
// Purpose  : Self-checking bench for mat_gram_cplx_stream (ROWS=2, LEN=4).
//            Expected result pairs are computed from the loaded matrices and
//            queued at load time; a monitor pops and compares on each output
//            handshake. Directed steps cover reset, both modes, extreme
//            values, backpressure, throughput, mid-compute reset and beat
//            counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_gram_cplx_stream;

  localparam int DW    = 16;
  localparam int ROWS  = 2;
  localparam int LEN   = 4;
  localparam int ACC_W = 2*DW+1+$clog2(LEN);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NB    = ROWS * LEN;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [DW-1:0]    in_z_re_i, in_z_im_i, in_j_re_i, in_j_im_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [RW-1:0]           out_row_o, out_col_o;
  logic signed [ACC_W-1:0] out_zj_re_o, out_zj_im_o, out_jj_re_o, out_jj_im_o;
  logic                    out_last_o;
  logic                    busy_o;

  mat_gram_cplx_stream #(.DW(DW), .ROWS(ROWS), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_z_re_i  (in_z_re_i),
    .in_z_im_i  (in_z_im_i),
    .in_j_re_i  (in_j_re_i),
    .in_j_im_i  (in_j_im_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_row_o  (out_row_o),
    .out_col_o  (out_col_o),
    .out_zj_re_o(out_zj_re_o),
    .out_zj_im_o(out_zj_im_o),
    .out_jj_re_o(out_jj_re_o),
    .out_jj_im_o(out_jj_im_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]           row;
    logic [RW-1:0]           col;
    logic signed [ACC_W-1:0] zjre, zjim, jjre, jjim;
    logic                    last;
  } exp_t;

  exp_t   sb[$];
  longint zr_m[NB], zi_m[NB], jr_m[NB], ji_m[NB];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor and accepted-beat counter, sampled just after the
  // falling edge once the bench has settled its inputs.
  always begin
    @(negedge clk);
    #1;
    if (!rst && in_valid_i && in_ready_o) beats++;
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("row",   out_row_o,   e.row);
        chk("col",   out_col_o,   e.col);
        chk("zj_re", out_zj_re_o, e.zjre);
        chk("zj_im", out_zj_im_o, e.zjim);
        chk("jj_re", out_jj_re_o, e.jjre);
        chk("jj_im", out_jj_im_o, e.jjim);
        chk("last",  out_last_o,  e.last);
      end
    end
  end

  task automatic set_all(input longint zr, input longint zi,
                         input longint jr, input longint ji);
    for (int i = 0; i < NB; i++) begin
      zr_m[i] = zr; zi_m[i] = zi; jr_m[i] = jr; ji_m[i] = ji;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < NB; i++) begin
      zr_m[i] = longint'($urandom_range(0, 65535)) - 32768;
      zi_m[i] = longint'($urandom_range(0, 65535)) - 32768;
      jr_m[i] = longint'($urandom_range(0, 65535)) - 32768;
      ji_m[i] = longint'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Reference model: row r of Z (and J) against row c of J.
  task automatic push_exp(input logic m);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ROWS; c++) begin
        longint a, b, p, q;
        exp_t   e;
        a = 0; b = 0; p = 0; q = 0;
        for (int k = 0; k < LEN; k++) begin
          int x, y;
          x = r*LEN + k;
          y = c*LEN + k;
          a += zr_m[x]*jr_m[y] + zi_m[x]*ji_m[y];
          p += jr_m[x]*jr_m[y] + ji_m[x]*ji_m[y];
          if (m) begin
            b += zr_m[x]*ji_m[y] - zi_m[x]*jr_m[y];
            q += jr_m[x]*ji_m[y] - ji_m[x]*jr_m[y];
          end else begin
            b += zi_m[x]*jr_m[y] - zr_m[x]*ji_m[y];
            q += ji_m[x]*jr_m[y] - jr_m[x]*ji_m[y];
          end
        end
        e.row  = RW'(r);
        e.col  = RW'(c);
        e.zjre = ACC_W'(a);
        e.zjim = ACC_W'(b);
        e.jjre = ACC_W'(p);
        e.jjim = ACC_W'(q);
        e.last = (r == ROWS-1) && (c == ROWS-1);
        sb.push_back(e);
      end
    end
  endtask

  // Drives NB beats; mode is inverted after the first beat so a design that
  // does not latch it is caught. Returns on the falling edge that presents
  // the last beat.
  task automatic load_set(input logic m, input bit gaps);
    int b, g;
    b = 0; g = 0;
    while (b < NB && g < 2000) begin
      @(negedge clk);
      g++;
      mode_i     = (b == 0) ? m : !m;
      in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_z_re_i  = DW'(zr_m[b]);
      in_z_im_i  = DW'(zi_m[b]);
      in_j_re_i  = DW'(jr_m[b]);
      in_j_im_i  = DW'(ji_m[b]);
      if (in_valid_i && in_ready_o) b++;
    end
    chk("load_done", b, NB);
  endtask

  task automatic wait_out(output int t);
    int g;
    g = 0;
    while (!out_valid_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    t = cyc;
    chk("out_valid_seen", out_valid_o, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (!(sb.size() == 0 && in_ready_o) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_done", (sb.size() == 0 && in_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, hn;
    logic [RW-1:0]           h_row, h_col;
    logic signed [ACC_W-1:0] h_zr, h_ji;

    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; mode_i = 1'b0;
    in_z_re_i = '0; in_z_im_i = '0; in_j_re_i = '0; in_j_im_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  in_ready_o,  1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy",      busy_o,      0);
    chk("rst_last",      out_last_o,  0);
    chk("rst_zj_re",     out_zj_re_o, 0);
    chk("rst_jj_im",     out_jj_im_o, 0);

    // All ones, mode 0, with first-result latency
    set_all(1, 0, 1, 0);
    push_exp(1'b0);
    beats = 0;
    load_set(1'b0, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    t0 = cyc;
    chk("enter_busy",    busy_o,     1);
    chk("in_ready_drop", in_ready_o, 0);
    wait_out(t1);
    chk("first_latency", t1 - t0, LEN + 3);
    drain();
    chk("beats_a", beats, NB);

    // z = 0+1i, j = 1+0i in both modes
    set_all(0, 1, 1, 0);
    push_exp(1'b0);
    load_set(1'b0, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    drain();
    push_exp(1'b1);
    load_set(1'b1, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    drain();

    // Most negative samples, gapped valid, valid held high during compute
    set_all(-32768, -32768, -32768, -32768);
    push_exp(1'b0);
    beats = 0;
    load_set(1'b0, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b1;
    chk("no_ready_in_compute", in_ready_o, 0);
    drain();
    in_valid_i = 1'b0;
    chk("beats_c", beats, NB);

    // Random data, mode 1, gapped valid
    set_rand();
    push_exp(1'b1);
    load_set(1'b1, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b0;
    drain();

    // Backpressure on the first result, then throughput after release
    set_rand();
    push_exp(1'b0);
    out_ready_i = 1'b0;
    load_set(1'b0, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    wait_out(t1);
    h_row = out_row_o; h_col = out_col_o;
    h_zr  = out_zj_re_o; h_ji = out_jj_im_o;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid_o, 1);
      chk("bp_row",   out_row_o,   h_row);
      chk("bp_col",   out_col_o,   h_col);
      chk("bp_zj_re", out_zj_re_o, h_zr);
      chk("bp_jj_im", out_jj_im_o, h_ji);
    end
    out_ready_i = 1'b1;
    hn = cyc;
    @(negedge clk);
    wait_out(t1);
    chk("throughput", t1 - hn, LEN + 4);
    drain();

    // Reset in the middle of COMPUTE discards the set
    set_rand();
    push_exp(1'b0);
    load_set(1'b0, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_in_ready",  in_ready_o,  1);
    chk("mid_rst_out_valid", out_valid_o, 0);
    chk("mid_rst_busy",      busy_o,      0);
    rst = 1'b0;
    set_rand();
    push_exp(1'b1);
    load_set(1'b1, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
